// File: rtl/output_buffer_interface_pkg.sv
// Constants shared by the network-process buffer interfaces: FSM state
// encodings, packet descriptor codes and the word-position format check.
package output_buffer_interface_pkg;

  typedef enum logic [1:0] {
    idle_s     = 2'b00,
    rd_req_s   = 2'b01,
    wait_ack_s = 2'b10
  } obi_state_t;

  // Descriptor code carried in bits [133:132] of every packet word.
  typedef enum logic [1:0] {
    desc_head = 2'b01,
    desc_tail = 2'b10,
    desc_body = 2'b11
  } desc_t;

  localparam logic [6:0] last_word_idx = 7'd127;

  // A packet must open with a head word, and a full-length packet must close with a tail.
  function automatic logic desc_error(input logic [6:0] idx, input logic [1:0] desc);
    return ((idx == 7'd0) && (desc != desc_head)) ||
           ((idx == last_word_idx) && (desc != desc_tail));
  endfunction

endpackage

// File: rtl/output_buffer_interface.sv
// Reads a packet, word by word, out of the packet buffer for a bufid handed
// over by the scheduler, forwards it to the transmit path and frees the buffer.
module output_buffer_interface
  import output_buffer_interface_pkg::*;
(
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         i_pkt_bufid_wr,
  input  logic [8:0]   iv_pkt_bufid,
  output logic         o_pkt_bufid_ack,
  output logic         o_pkt_rd,
  output logic [15:0]  ov_pkt_raddr,
  input  logic         i_pkt_rd_ack,
  input  logic [133:0] iv_pkt,
  input  logic         i_tx_fifo_almost_full,
  output logic         o_pkt_wr,
  output logic [133:0] ov_pkt,
  output logic         o_pkt_bufid_release,
  output logic [8:0]   ov_pkt_bufid_release,
  output logic         o_pkt_err,
  output logic [1:0]   ov_output_buf_interface_state
);

  obi_state_t  state;
  logic [8:0]  bufid;
  logic [6:0]  word_idx;
  logic [1:0]  ack_desc;
  logic        ends_pkt;

  assign ack_desc = iv_pkt[133:132];
  // Index 127 always ends the packet; the index never wraps.
  assign ends_pkt = (ack_desc == desc_tail) || (word_idx == last_word_idx);
  assign ov_output_buf_interface_state = state;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state                <= idle_s;
      bufid                <= '0;
      word_idx             <= '0;
      o_pkt_bufid_ack      <= 1'b0;
      o_pkt_rd             <= 1'b0;
      ov_pkt_raddr         <= '0;
      o_pkt_wr             <= 1'b0;
      ov_pkt               <= '0;
      o_pkt_bufid_release  <= 1'b0;
      ov_pkt_bufid_release <= '0;
      o_pkt_err            <= 1'b0;
    end else begin
      o_pkt_bufid_ack      <= 1'b0;
      o_pkt_wr             <= 1'b0;
      ov_pkt               <= '0;
      o_pkt_bufid_release  <= 1'b0;
      ov_pkt_bufid_release <= '0;
      o_pkt_err            <= 1'b0;
      case (state)
        idle_s: begin
          if (i_pkt_bufid_wr) begin
            bufid           <= iv_pkt_bufid;
            o_pkt_bufid_ack <= 1'b1;
            ov_pkt_raddr    <= {iv_pkt_bufid, 7'd0};
            word_idx        <= '0;
            state           <= rd_req_s;
          end
        end
        rd_req_s: begin
          if (!i_tx_fifo_almost_full) begin
            o_pkt_rd <= 1'b1;
            state    <= wait_ack_s;
          end
        end
        wait_ack_s: begin
          // Backpressure is only consulted before a request, so an acked word is never lost.
          if (i_pkt_rd_ack && o_pkt_rd) begin
            o_pkt_rd  <= 1'b0;
            o_pkt_wr  <= 1'b1;
            ov_pkt    <= iv_pkt;
            o_pkt_err <= desc_error(word_idx, ack_desc);
            if (ends_pkt) begin
              o_pkt_bufid_release  <= 1'b1;
              ov_pkt_bufid_release <= bufid;
              state                <= idle_s;
            end else begin
              word_idx     <= word_idx + 7'd1;
              ov_pkt_raddr <= ov_pkt_raddr + 16'd1;
              state        <= rd_req_s;
            end
          end
        end
        default: begin
          o_pkt_rd <= 1'b0;
          state    <= idle_s;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_buffer_interface.sv
// Bench acting as scheduler and packet buffer around output_buffer_interface,
// checking every cycle against a packet-level model of the expected transfer.
module tb_output_buffer_interface;

  logic         clk_sys = 1'b0;
  logic         reset;
  logic         i_pkt_bufid_wr;
  logic [8:0]   iv_pkt_bufid;
  logic         o_pkt_bufid_ack;
  logic         o_pkt_rd;
  logic [15:0]  ov_pkt_raddr;
  logic         i_pkt_rd_ack;
  logic [133:0] iv_pkt;
  logic         i_tx_fifo_almost_full;
  logic         o_pkt_wr;
  logic [133:0] ov_pkt;
  logic         o_pkt_bufid_release;
  logic [8:0]   ov_pkt_bufid_release;
  logic         o_pkt_err;
  logic [1:0]   ov_output_buf_interface_state;

  int checks = 0;
  int errors = 0;
  logic [133:0] words [128];

  output_buffer_interface dut (
    .clk_sys                       (clk_sys),
    .reset                         (reset),
    .i_pkt_bufid_wr                (i_pkt_bufid_wr),
    .iv_pkt_bufid                  (iv_pkt_bufid),
    .o_pkt_bufid_ack               (o_pkt_bufid_ack),
    .o_pkt_rd                      (o_pkt_rd),
    .ov_pkt_raddr                  (ov_pkt_raddr),
    .i_pkt_rd_ack                  (i_pkt_rd_ack),
    .iv_pkt                        (iv_pkt),
    .i_tx_fifo_almost_full         (i_tx_fifo_almost_full),
    .o_pkt_wr                      (o_pkt_wr),
    .ov_pkt                        (ov_pkt),
    .o_pkt_bufid_release           (o_pkt_bufid_release),
    .ov_pkt_bufid_release          (ov_pkt_bufid_release),
    .o_pkt_err                     (o_pkt_err),
    .ov_output_buf_interface_state (ov_output_buf_interface_state)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [199:0] observed, input logic [199:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [133:0] rand_word(input logic [1:0] desc);
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return {desc, r[131:0]};
  endfunction

  function automatic logic [165:0] all_outputs();
    return {o_pkt_bufid_ack, o_pkt_rd, ov_pkt_raddr, o_pkt_wr, ov_pkt, o_pkt_bufid_release,
            ov_pkt_bufid_release, o_pkt_err, ov_output_buf_interface_state};
  endfunction

  // Word 0 is head (or body when a bad head is wanted); a tail optionally closes word nwords-1.
  task automatic build_packet(input int nwords, input bit head_ok, input bit tail_present);
    for (int i = 0; i < 128; i++) begin
      logic [1:0] d;
      d = 2'b11;
      if (i == 0 && head_ok) d = 2'b01;
      if (tail_present && i == nwords - 1) d = 2'b10;
      words[i] = rand_word(d);
    end
  endtask

  function automatic int model_len();
    for (int i = 0; i < 128; i++)
      if (words[i][133:132] == 2'b10) return i + 1;
    return 128;
  endfunction

  function automatic bit model_err(input int idx);
    return (idx == 0 && words[0][133:132] != 2'b01) || (idx == 127 && words[127][133:132] != 2'b10);
  endfunction

  task automatic run_packet(input logic [8:0] b, input int nwords, input bit head_ok, input bit tail_present,
                            input int delay_mode, input int af_mode, input bit offer_second,
                            input logic [8:0] b2, input int abort_at);
    int k = 0;
    int cyc = 0;
    int len;
    int waitc = 0;
    int dly;
    int af_hold = 0;
    bit given_ack = 0;
    bit was_ack;
    bit prev_rd = 0;
    bit prev_af = 0;
    bit done = 0;
    bit last;
    logic [15:0] prev_addr = '0;
    build_packet(nwords, head_ok, tail_present);
    len = model_len();
    dly = (delay_mode < 0) ? int'($urandom_range(3)) : delay_mode;
    i_pkt_bufid_wr = 1'b1;
    iv_pkt_bufid   = b;
    while (!done && cyc < 3000) begin
      @(negedge clk_sys);
      cyc++;
      was_ack = given_ack;
      check("bufid_ack", o_pkt_bufid_ack, cyc == 1);
      if (cyc == 1) begin
        check("state_after_accept", ov_output_buf_interface_state, 2'b01);
        check("rd_after_accept", o_pkt_rd, 1'b0);
        i_pkt_bufid_wr = offer_second;
        iv_pkt_bufid   = offer_second ? b2 : 9'd0;
      end
      if (was_ack) begin
        last = (k == len);
        check("pkt_wr", o_pkt_wr, 1'b1);
        check("pkt_data", ov_pkt, words[k-1]);
        check("pkt_err", o_pkt_err, model_err(k - 1));
        check("rd_drop_after_ack", o_pkt_rd, 1'b0);
        check("release", o_pkt_bufid_release, last);
        check("release_id", ov_pkt_bufid_release, last ? b : 9'd0);
        if (last) begin
          check("state_idle_after_release", ov_output_buf_interface_state, 2'b00);
          done = 1;
        end
      end else begin
        check("quiet_outputs", {o_pkt_wr, ov_pkt, o_pkt_err, o_pkt_bufid_release, ov_pkt_bufid_release}, '0);
        if (prev_rd) begin
          check("rd_hold", o_pkt_rd, 1'b1);
          check("addr_hold", ov_pkt_raddr, prev_addr);
        end
      end
      if (o_pkt_rd && !prev_rd) check("rd_under_backpressure", prev_af, 1'b0);
      if (o_pkt_rd) begin
        check("raddr", ov_pkt_raddr, {b, 7'd0} + 16'(k));
        check("state_wait_ack", ov_output_buf_interface_state, 2'b10);
      end
      given_ack    = 0;
      i_pkt_rd_ack = 1'b0;
      iv_pkt       = '0;
      if (!done && abort_at == k && o_pkt_rd) begin
        reset = 1'b1;
        i_tx_fifo_almost_full = 1'b0;
        @(negedge clk_sys);
        check("abort_outputs_zero", all_outputs(), '0);
        reset = 1'b0;
        repeat (3) begin
          @(negedge clk_sys);
          check("abort_no_release", all_outputs(), '0);
        end
        return;
      end
      if (!done) begin
        if (o_pkt_rd) begin
          if (waitc >= dly) begin
            i_pkt_rd_ack = 1'b1;
            iv_pkt       = words[k];
            k++;
            given_ack = 1;
            waitc     = 0;
            dly = (delay_mode < 0) ? int'($urandom_range(3)) : delay_mode;
          end else begin
            waitc++;
          end
        end else if ($urandom_range(2) == 0) begin
          i_pkt_rd_ack = 1'b1;
          iv_pkt       = rand_word(2'($urandom_range(3)));
        end
        if (af_mode == 2 && (cyc == 1 || was_ack)) af_hold = 4;
        if (af_mode == 1) i_tx_fifo_almost_full = ($urandom_range(2) == 0);
        else if (af_hold > 0) begin
          i_tx_fifo_almost_full = 1'b1;
          af_hold--;
        end else i_tx_fifo_almost_full = 1'b0;
      end else begin
        i_tx_fifo_almost_full = 1'b0;
      end
      prev_af   = i_tx_fifo_almost_full;
      prev_rd   = o_pkt_rd;
      prev_addr = ov_pkt_raddr;
    end
    if (!done) check("packet_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    i_pkt_bufid_wr = 1'b0;
    iv_pkt_bufid = '0;
    i_pkt_rd_ack = 1'b0;
    iv_pkt = '0;
    i_tx_fifo_almost_full = 1'b0;
    @(negedge clk_sys);
    i_pkt_bufid_wr = 1'b1;
    iv_pkt_bufid   = 9'h0AA;
    @(negedge clk_sys);
    check("reset_state", all_outputs(), '0);
    reset = 1'b0;
    i_pkt_bufid_wr = 1'b0;
    iv_pkt_bufid   = '0;

    // Stray read acks while idle must be ignored.
    repeat (4) begin
      i_pkt_rd_ack = 1'b1;
      iv_pkt = rand_word(2'b10);
      @(negedge clk_sys);
      check("idle_stray_ack", all_outputs(), '0);
    end
    i_pkt_rd_ack = 1'b0;
    iv_pkt = '0;

    run_packet(9'h005, 3, 1, 1, 0, 0, 0, 9'h000, -1);
    run_packet(9'h0A3, 2, 1, 1, 5, 0, 0, 9'h000, -1);
    run_packet(9'h011, 4, 1, 1, 0, 2, 0, 9'h000, -1);
    run_packet(9'h1FF, 128, 1, 0, -1, 1, 0, 9'h000, -1);
    run_packet(9'h100, 128, 1, 1, 0, 0, 0, 9'h000, -1);
    run_packet(9'h020, 5, 1, 1, -1, 1, 1, 9'h0C4, -1);
    run_packet(9'h0C4, 3, 1, 1, -1, 0, 0, 9'h000, -1);
    run_packet(9'h033, 3, 0, 1, 1, 0, 0, 9'h000, -1);
    for (int p = 0; p < 6; p++)
      run_packet(9'($urandom_range(511)), int'($urandom_range(1, 20)), 1'($urandom_range(1)), 1'b1,
                 -1, int'($urandom_range(2)), 0, 9'h000, -1);
    run_packet(9'h077, 6, 1, 1, 0, 0, 0, 9'h000, 2);
    run_packet(9'h078, 2, 1, 1, -1, 1, 0, 9'h000, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
